// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between fetch and load/store.
// Data side has priority, a starve counter forces fetch through, and sub-word stores run as RMW.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_req,
   input  logic [`WORD_LEN-1:0] i_addr,
   output logic                 i_gnt,
   output logic                 i_rvalid,
   output logic [`WORD_LEN-1:0] i_rdata,
   input  logic                 d_req,
   input  logic [`WORD_LEN-1:0] d_addr,
   input  logic                 d_wen,
   input  logic [3:0]           d_wstrb,
   input  logic [`WORD_LEN-1:0] d_wdata,
   output logic                 d_gnt,
   output logic                 d_rvalid,
   output logic [`WORD_LEN-1:0] d_rdata,
   output logic [`WORD_LEN-1:0] m_addr,
   output logic                 m_wen,
   output logic [`WORD_LEN-1:0] m_wdata,
   input  logic [`WORD_LEN-1:0] m_rdata,
   output logic [0:0]           dbg_state,
   output logic [3:0]           dbg_starve_cnt
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RMW  = 1'b1;
   localparam logic [3:0] CNT_MAX = 4'(STARVE_LIMIT);

   // Handshake: a requester holds req and its fields stable until it sees gnt high in the
   // same cycle; the accepted read answers with a one-cycle rvalid pulse on the next cycle.

   logic [0:0]           state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 i_rvalid_q, i_rvalid_d;
   logic                 d_rvalid_q, d_rvalid_d;
   logic [`WORD_LEN-1:0] rmw_addr_q, rmw_addr_d;
   logic [3:0]           rmw_strb_q, rmw_strb_d;
   logic [`WORD_LEN-1:0] rmw_wdata_q, rmw_wdata_d;

   logic d_store;
   logic d_full;
   logic force_fetch;

   // A store with no byte enabled has nothing to write, so it behaves as a load.
   assign d_store     = d_wen && (d_wstrb != 4'b0000);
   assign d_full      = (d_wstrb == 4'b1111);
   assign force_fetch = i_req && (cnt_q == CNT_MAX);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rmw_addr_d  = rmw_addr_q;
      rmw_strb_d  = rmw_strb_q;
      rmw_wdata_d = rmw_wdata_q;
      i_rvalid_d  = 1'b0;
      d_rvalid_d  = 1'b0;
      i_gnt       = 1'b0;
      d_gnt       = 1'b0;
      m_addr      = i_addr;
      m_wen       = 1'b0;
      m_wdata     = d_wdata;

      if (state_q == ST_RMW) begin
         m_addr  = rmw_addr_q;
         m_wen   = rst_n;
         for (int k = 0; k < 4; k++) begin
            m_wdata[8*k +: 8] = rmw_strb_q[k] ? rmw_wdata_q[8*k +: 8] : m_rdata[8*k +: 8];
         end
         state_d = ST_IDLE;
      end else begin
         d_gnt = rst_n && d_req && !force_fetch;
         i_gnt = rst_n && i_req && !d_gnt;

         if (d_gnt) begin
            m_addr = d_addr;
            if (d_store && d_full) begin
               m_wen = 1'b1;
            end else if (d_store) begin
               rmw_addr_d  = d_addr;
               rmw_strb_d  = d_wstrb;
               rmw_wdata_d = d_wdata;
               state_d     = ST_RMW;
            end else begin
               d_rvalid_d = 1'b1;
            end
         end

         if (i_gnt) begin
            i_rvalid_d = 1'b1;
         end

         if (!i_req || i_gnt) begin
            cnt_d = 4'd0;
         end else if (d_gnt && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         i_rvalid_q  <= 1'b0;
         d_rvalid_q  <= 1'b0;
         rmw_addr_q  <= '0;
         rmw_strb_q  <= 4'b0000;
         rmw_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         i_rvalid_q  <= i_rvalid_d;
         d_rvalid_q  <= d_rvalid_d;
         rmw_addr_q  <= rmw_addr_d;
         rmw_strb_q  <= rmw_strb_d;
         rmw_wdata_q <= rmw_wdata_d;
      end
   end

   // The memory output register already holds the word, so both read buses share it.
   assign i_rvalid       = i_rvalid_q;
   assign d_rvalid       = d_rvalid_q;
   assign i_rdata        = m_rdata;
   assign d_rdata        = m_rdata;
   assign dbg_state      = state_q;
   assign dbg_starve_cnt = cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a behavioural single-port memory.
// Inputs change 1ns after posedge; outputs are sampled on the negedge.
`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt, i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req, d_wen;
   logic [31:0] d_addr, d_wdata;
   logic [3:0]  d_wstrb;
   logic        d_gnt, d_rvalid;
   logic [31:0] d_rdata;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_wen;
   logic [0:0]  dbg_state;
   logic [3:0]  dbg_starve_cnt;

   logic [31:0] mem [0:255];
   logic        bd_we;
   logic [7:0]  bd_idx;
   logic [31:0] bd_data;
   logic        pend_i, pend_d;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .dbg_state(dbg_state), .dbg_starve_cnt(dbg_starve_cnt)
   );

   // Single-port synchronous memory, one-cycle read latency, plus a backdoor preload port.
   always @(posedge clk) begin
      if (bd_we) mem[bd_idx] <= bd_data;
      else if (m_wen) mem[m_addr[9:2]] <= m_wdata;
      m_rdata <= mem[m_addr[9:2]];
   end

   // A request must stay up until granted.
   always @(negedge clk) begin
      if (!rst_n) begin
         pend_i <= 1'b0;
         pend_d <= 1'b0;
      end else begin
         assert (!(pend_i && !i_req)) else $error("fetch request withdrawn before grant");
         assert (!(pend_d && !d_req)) else $error("data request withdrawn before grant");
         pend_i <= i_req && !i_gnt;
         pend_d <= d_req && !d_gnt;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] idx, input logic [31:0] data);
      bd_idx  = idx;
      bd_data = data;
      bd_we   = 1'b1;
      next_cycle();
      bd_we   = 1'b0;
   endtask

   task automatic drive_i(input logic req, input logic [31:0] addr);
      i_req  = req;
      i_addr = addr;
   endtask

   task automatic drive_d(input logic req, input logic wen, input logic [3:0] strb,
                          input logic [31:0] addr, input logic [31:0] wdata);
      d_req   = req;
      d_wen   = wen;
      d_wstrb = strb;
      d_addr  = addr;
      d_wdata = wdata;
   endtask

   initial begin
      logic exp_d;
      logic prev_d, prev_i;

      rst_n = 1'b0;
      bd_we = 1'b0; bd_idx = 8'd0; bd_data = 32'd0;
      drive_i(1'b0, 32'h0);
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

      preload(8'd0,  32'hA000_0000);
      preload(8'd1,  32'hA111_1111);
      preload(8'd2,  32'hA222_2222);
      preload(8'd3,  32'hA333_3333);
      preload(8'd8,  32'h1122_3344);
      preload(8'd12, 32'h5555_5555);
      preload(8'd16, 32'h0BAD_F00D);

      // Requests held while reset is asserted must not be granted.
      drive_i(1'b1, 32'h0);
      drive_d(1'b1, 1'b1, 4'hF, 32'h10, 32'h1234_5678);
      @(negedge clk);
      check("rst_i_gnt",    32'(i_gnt),          32'd0);
      check("rst_d_gnt",    32'(d_gnt),          32'd0);
      check("rst_m_wen",    32'(m_wen),          32'd0);
      check("rst_i_rvalid", 32'(i_rvalid),       32'd0);
      check("rst_d_rvalid", 32'(d_rvalid),       32'd0);
      check("rst_state",    32'(dbg_state),      32'd0);
      check("rst_cnt",      32'(dbg_starve_cnt), 32'd0);
      next_cycle();
      drive_i(1'b0, 32'h0);
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      next_cycle();
      rst_n = 1'b1;
      next_cycle();

      // Fetch-only stream of three words.
      drive_i(1'b1, 32'h0);
      @(negedge clk);
      check("t1_gnt0", 32'(i_gnt), 32'd1);
      check("t1_rv0",  32'(i_rvalid), 32'd0);
      next_cycle(); drive_i(1'b1, 32'h4);
      @(negedge clk);
      check("t1_gnt1", 32'(i_gnt), 32'd1);
      check("t1_rv1",  32'(i_rvalid), 32'd1);
      check("t1_rd1",  i_rdata, 32'hA000_0000);
      next_cycle(); drive_i(1'b1, 32'h8);
      @(negedge clk);
      check("t1_gnt2", 32'(i_gnt), 32'd1);
      check("t1_rd2",  i_rdata, 32'hA111_1111);
      check("t1_drv2", 32'(d_rvalid), 32'd0);
      next_cycle(); drive_i(1'b0, 32'h0);
      @(negedge clk);
      check("t1_gnt3", 32'(i_gnt), 32'd0);
      check("t1_rv3",  32'(i_rvalid), 32'd1);
      check("t1_rd3",  i_rdata, 32'hA222_2222);
      check("t1_drv3", 32'(d_rvalid), 32'd0);
      next_cycle();
      @(negedge clk);
      check("t1_rv4",  32'(i_rvalid), 32'd0);

      // Both requesters busy: D,D,D,D,I repeating with the starve counter.
      next_cycle();
      drive_i(1'b1, 32'h0);
      drive_d(1'b1, 1'b0, 4'h0, 32'h4, 32'h0);
      prev_d = 1'b0; prev_i = 1'b0;
      for (int n = 0; n < 10; n++) begin
         exp_d = ((n % 5) != 4);
         @(negedge clk);
         check($sformatf("t2_dgnt%0d", n), 32'(d_gnt), 32'(exp_d));
         check($sformatf("t2_ignt%0d", n), 32'(i_gnt), 32'(!exp_d));
         check($sformatf("t2_cnt%0d", n),  32'(dbg_starve_cnt), 32'(n % 5));
         check($sformatf("t2_drv%0d", n),  32'(d_rvalid), 32'(prev_d));
         check($sformatf("t2_irv%0d", n),  32'(i_rvalid), 32'(prev_i));
         if (prev_d) check($sformatf("t2_drd%0d", n), d_rdata, 32'hA111_1111);
         if (prev_i) check($sformatf("t2_ird%0d", n), i_rdata, 32'hA000_0000);
         prev_d = exp_d; prev_i = !exp_d;
         next_cycle();
      end
      drive_i(1'b0, 32'h0);
      @(negedge clk);
      check("t2_tail_dgnt", 32'(d_gnt), 32'd1);
      check("t2_tail_cnt",  32'(dbg_starve_cnt), 32'd0);
      next_cycle();
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("t2_idle_cnt",  32'(dbg_starve_cnt), 32'd0);
      next_cycle();

      // Full-word store followed by a load of the same word.
      drive_d(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
      @(negedge clk);
      check("t3_gnt",   32'(d_gnt), 32'd1);
      check("t3_wen0",  32'(m_wen), 32'd1);
      check("t3_wdata", m_wdata, 32'hDEAD_BEEF);
      check("t3_addr",  m_addr, 32'h10);
      next_cycle();
      drive_d(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clk);
      check("t3_ld_gnt", 32'(d_gnt), 32'd1);
      check("t3_wen1",   32'(m_wen), 32'd0);
      check("t3_st_rv",  32'(d_rvalid), 32'd0);
      next_cycle();
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("t3_wen2",  32'(m_wen), 32'd0);
      check("t3_rv",    32'(d_rvalid), 32'd1);
      check("t3_rdata", d_rdata, 32'hDEAD_BEEF);
      next_cycle();
      @(negedge clk);
      check("t3_rv_end", 32'(d_rvalid), 32'd0);

      // Partial store as read-modify-write, with a fetch waiting through the RMW cycle.
      next_cycle();
      drive_d(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_AA00);
      @(negedge clk);
      check("t4_gnt",   32'(d_gnt), 32'd1);
      check("t4_wen0",  32'(m_wen), 32'd0);
      next_cycle();
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      drive_i(1'b1, 32'hC);
      @(negedge clk);
      check("t4_state", 32'(dbg_state), 32'd1);
      check("t4_igntr", 32'(i_gnt), 32'd0);
      check("t4_dgntr", 32'(d_gnt), 32'd0);
      check("t4_wen1",  32'(m_wen), 32'd1);
      check("t4_maddr", m_addr, 32'h20);
      check("t4_wdata", m_wdata, 32'h1122_AA44);
      next_cycle();
      @(negedge clk);
      check("t4_ignt",  32'(i_gnt), 32'd1);
      check("t4_wen2",  32'(m_wen), 32'd0);
      check("t4_idle",  32'(dbg_state), 32'd0);
      check("t4_drv",   32'(d_rvalid), 32'd0);
      next_cycle();
      drive_i(1'b0, 32'h0);
      @(negedge clk);
      check("t4_irv",   32'(i_rvalid), 32'd1);
      check("t4_ird",   i_rdata, 32'hA333_3333);
      check("t4_mem",   mem[8], 32'h1122_AA44);

      // Reset pulsed during the RMW cycle abandons the write.
      next_cycle();
      drive_d(1'b1, 1'b1, 4'b0001, 32'h30, 32'h0000_00AA);
      @(negedge clk);
      check("t5_gnt", 32'(d_gnt), 32'd1);
      next_cycle();
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      #1 rst_n = 1'b0;
      @(negedge clk);
      check("t5_state", 32'(dbg_state), 32'd0);
      check("t5_wen",   32'(m_wen), 32'd0);
      check("t5_irv",   32'(i_rvalid), 32'd0);
      check("t5_drv",   32'(d_rvalid), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      @(negedge clk);
      check("t5_state_rel", 32'(dbg_state), 32'd0);
      check("t5_wen_rel",   32'(m_wen), 32'd0);
      next_cycle();
      @(negedge clk);
      check("t5_mem",     mem[12], 32'h5555_5555);
      check("t5_drv_rel", 32'(d_rvalid), 32'd0);
      check("t5_irv_rel", 32'(i_rvalid), 32'd0);

      // Store with no strobes behaves as a load.
      next_cycle();
      drive_d(1'b1, 1'b1, 4'b0000, 32'h40, 32'hFFFF_FFFF);
      @(negedge clk);
      check("t6_gnt",   32'(d_gnt), 32'd1);
      check("t6_wen0",  32'(m_wen), 32'd0);
      next_cycle();
      drive_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      check("t6_state", 32'(dbg_state), 32'd0);
      check("t6_wen1",  32'(m_wen), 32'd0);
      check("t6_rv",    32'(d_rvalid), 32'd1);
      check("t6_rdata", d_rdata, 32'h0BAD_F00D);
      check("t6_mem",   mem[16], 32'h0BAD_F00D);

      next_cycle();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch requester and the load/store requester.
- The memory has one-cycle read latency.
- Provides per-requester req/gnt/rvalid handshakes with data-side priority and an anti-starvation counter for fetch.
- Sequences sub-word stores as a two-cycle read-modify-write.
- Sits between core fetch/LSU and the memory array.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while i_req is pending before fetch is forced a grant (range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  `WORD_LEN  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  i_rdata valid (registered)
- i_rdata  out  `WORD_LEN  fetched word
- d_req  in  1  data request; held with all d_* fields stable until d_gnt
- d_addr  in  `WORD_LEN  data byte address
- d_wen  in  1  1 = store, 0 = load
- d_wstrb  in  4  byte enables for stores
- d_wdata  in  `WORD_LEN  store data, byte-lane aligned
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  d_rdata valid (registered); loads only
- d_rdata  out  `WORD_LEN  loaded word
- m_addr  out  `WORD_LEN  memory byte address (memory uses [WORD_LEN-1:2])
- m_wen  out  1  memory write enable
- m_wdata  out  `WORD_LEN  memory write data
- m_rdata  in  `WORD_LEN  memory read data, valid one cycle after address

Behaviour:
- States: IDLE, RMW.
- Reset (rst_n=0, async):
  - state=IDLE, starve counter=0, i_rvalid=0, d_rvalid=0.
  - Latched RMW registers cleared.
  - i_gnt=d_gnt=m_wen=0 while reset is asserted.
- IDLE, grant selection each cycle:
  - If d_req and not (i_req and cnt==STARVE_LIMIT): grant data.
  - Else if i_req: grant fetch.
  - Else: no grant, m_wen=0.
  - At most one gnt per cycle.
- Granted fetch: m_addr=i_addr, m_wen=0. Next cycle i_rvalid=1, i_rdata=m_rdata.
- Granted load (d_wen=0, or d_wen=1 with d_wstrb=0000 treated as load): m_addr=d_addr, m_wen=0. Next cycle d_rvalid=1, d_rdata=m_rdata.
- Granted full store (d_wstrb=1111): m_addr=d_addr, m_wen=1, m_wdata=d_wdata. Completes at the edge; no rvalid.
- Granted partial store (any other nonzero strobe):
  - Cycle 0: d_gnt=1, m_addr=d_addr, m_wen=0. Latch addr, wstrb, wdata. Go to RMW.
  - RMW cycle: m_addr=latched addr, m_wen=1, m_wdata byte k = wstrb[k] ? wdata byte k : m_rdata byte k. No gnt to either side. Return to IDLE.
  - No rvalid.
- rvalid pulses are one cycle wide. Back-to-back grants are allowed every IDLE cycle (full throughput for reads).
- Responses return in grant order. A read granted the cycle after a write to the same word returns the new data.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each data grant while i_req=1.
  - Clears on a fetch grant or whenever i_req=0.
  - Unchanged during RMW.
- No address alignment check; d_rdata is the full word, and lane extraction belongs to the LSU.
- Reset asserted during RMW: write abandoned, memory word unmodified, no rvalid after reset release.
- Request withdrawn before gnt is a protocol violation (assertion in bench); no functional recovery required.

Test Plan:
- Reset then i_req only, i_addr=0x0,0x4,0x8 on consecutive cycles -> i_gnt every cycle; i_rvalid on cycles 1..3 with mem[0..2]; d_rvalid never set.
- i_req and d_req both held high, d loads, STARVE_LIMIT=4 -> grant pattern D,D,D,D,I repeating; counter back to 0 after each I grant.
- Store word 0xDEADBEEF to 0x10 (strobe 1111), next cycle load 0x10 -> m_wen for exactly 1 cycle; d_rdata=0xDEADBEEF one cycle after load grant.
- mem[0x20]=0x11223344; store d_wdata=0x0000AA00, strobe 0010 -> 2-cycle sequence with i_gnt=0 in RMW cycle; mem[0x20]=0x1122AA44; an i_req pending during RMW is granted the following cycle.
- rst_n pulsed low during RMW cycle of strobe 0001 store to 0x30 (old 0x55555555) -> mem[0x30] stays 0x55555555; i_rvalid=d_rvalid=0 immediately, state IDLE after release.
- Store with strobe 0000 to 0x40 -> treated as load: m_wen stays 0, d_rvalid=1 next cycle with mem[0x40].
